// File: rtl/mult_div_unit.sv
// Iterative MIPS32 multiply/divide unit holding the architectural HI/LO registers.
// Shift-add multiply and restoring divide, one bit per clock, sign fix-up in a final cycle.
module mult_div_unit #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [1:0]            MDU_op,
  input  logic [DATA_WIDTH-1:0] Src1,
  input  logic [DATA_WIDTH-1:0] Src2,
  input  logic                  mthi,
  input  logic                  mtlo,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] HI,
  output logic [DATA_WIDTH-1:0] LO
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [W-1:0]   ONE      = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W-1:0] ONE2     = {{(2*W-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0]  LAST_ITER = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t          state;
  logic            op_div;
  logic            sign_a;
  logic            sign_b;
  logic [W-1:0]    mag_a;
  logic [W-1:0]    mag_b;
  logic [W-1:0]    shift_q;
  logic [2*W-1:0]  acc;
  logic [CW-1:0]   count;

  logic            src1_neg;
  logic            src2_neg;
  logic [W-1:0]    src1_abs;
  logic [W-1:0]    src2_abs;

  logic [W:0]      mul_sum;
  logic [2*W-1:0]  mul_next;
  logic [W:0]      div_trial;
  logic [W-1:0]    div_diff;
  logic            div_ge;
  logic [W-1:0]    div_rem;
  logic [2*W-1:0]  div_next;

  logic [2*W-1:0]  prod;
  logic [W-1:0]    quo_raw;
  logic [W-1:0]    rem_raw;
  logic            div_zero;
  logic [W-1:0]    fix_hi;
  logic [W-1:0]    fix_lo;

  // Op code bit 0 clear means a signed operation.
  assign src1_neg = ~MDU_op[0] & Src1[W-1];
  assign src2_neg = ~MDU_op[0] & Src2[W-1];
  assign src1_abs = src1_neg ? (~Src1 + ONE) : Src1;
  assign src2_abs = src2_neg ? (~Src2 + ONE) : Src2;

  // Multiply: multiplier bits leave shift_q LSB-first; product bits shift into the low half.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (shift_q[0] ? mag_a : {W{1'b0}})};
  assign mul_next = {mul_sum, acc[W-1:1]};

  // Divide: remainder in the high half, quotient bits shift into the low half.
  assign div_trial = {acc[2*W-1:W], shift_q[W-1]};
  assign div_ge    = (div_trial >= {1'b0, mag_b});
  assign div_diff  = div_trial[W-1:0] - mag_b;
  assign div_rem   = div_ge ? div_diff : div_trial[W-1:0];
  assign div_next  = {div_rem, acc[W-2:0], div_ge};

  assign prod     = (~op_div & (sign_a ^ sign_b)) ? (~acc + ONE2) : acc;
  assign quo_raw  = acc[W-1:0];
  assign rem_raw  = acc[2*W-1:W];
  assign div_zero = (mag_b == {W{1'b0}});

  always_comb begin
    fix_hi = prod[2*W-1:W];
    fix_lo = prod[W-1:0];
    if (op_div) begin
      if (div_zero) begin
        // Divide by zero hands back the original dividend in HI.
        fix_hi = sign_a ? (~mag_a + ONE) : mag_a;
        fix_lo = {W{1'b1}};
      end else begin
        fix_hi = sign_a ? (~rem_raw + ONE) : rem_raw;
        fix_lo = (sign_a ^ sign_b) ? (~quo_raw + ONE) : quo_raw;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      op_div  <= 1'b0;
      sign_a  <= 1'b0;
      sign_b  <= 1'b0;
      mag_a   <= '0;
      mag_b   <= '0;
      shift_q <= '0;
      acc     <= '0;
      count   <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op_div  <= MDU_op[1];
            sign_a  <= src1_neg;
            sign_b  <= src2_neg;
            mag_a   <= src1_abs;
            mag_b   <= src2_abs;
            shift_q <= MDU_op[1] ? src1_abs : src2_abs;
            acc     <= '0;
            count   <= '0;
            busy    <= 1'b1;
            state   <= CALC;
          end else begin
            if (mthi) HI <= Src1;
            if (mtlo) LO <= Src1;
          end
        end
        CALC: begin
          if (op_div) begin
            acc     <= div_next;
            shift_q <= {shift_q[W-2:0], 1'b0};
          end else begin
            acc     <= mul_next;
            shift_q <= {1'b0, shift_q[W-1:1]};
          end
          count <= count + 1'b1;
          if (count == LAST_ITER) state <= FIX;
        end
        FIX: begin
          HI    <= fix_hi;
          LO    <= fix_lo;
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit: each scenario task drives vectors
// and compares HI/LO/busy/done against hand-computed values.
module tb_mult_div_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [1:0]   MDU_op;
  logic [W-1:0] Src1;
  logic [W-1:0] Src2;
  logic         mthi;
  logic         mtlo;
  logic         busy;
  logic         done;
  logic [W-1:0] HI;
  logic [W-1:0] LO;

  int pass_cnt  = 0;
  int total_cnt = 0;

  mult_div_unit #(.DATA_WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .MDU_op (MDU_op),
    .Src1   (Src1),
    .Src2   (Src2),
    .mthi   (mthi),
    .mtlo   (mtlo),
    .busy   (busy),
    .done   (done),
    .HI     (HI),
    .LO     (LO)
  );

  always #5 clk = ~clk;

  // Launch one op, optionally poke start or mthi mid-operation, and wait (bounded) for done.
  task automatic run_op(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input bit with_mtlo, input int mid_cycle, input bit mid_is_start,
                        output int busy_cycles, output bit got_done, output bit held);
    logic [W-1:0] old_hi;
    logic [W-1:0] old_lo;
    busy_cycles = 0;
    got_done    = 1'b0;
    held        = 1'b1;
    @(negedge clk);
    old_hi = HI;
    old_lo = LO;
    start  = 1'b1;
    MDU_op = op;
    Src1   = a;
    Src2   = b;
    mtlo   = with_mtlo;
    @(negedge clk);
    start  = 1'b0;
    mtlo   = 1'b0;
    Src1   = 32'hDEADBEEF;
    Src2   = 32'h0BADF00D;
    MDU_op = 2'b11;
    for (int n = 0; n < 100; n++) begin
      if (done) begin
        got_done = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (HI !== old_hi || LO !== old_lo) held = 1'b0;
      if (n == mid_cycle) begin
        if (mid_is_start) start = 1'b1;
        else mthi = 1'b1;
        Src1   = 32'h55AA55AA;
        Src2   = 32'h00000003;
        MDU_op = 2'b01;
      end
      @(negedge clk);
      start = 1'b0;
      mthi  = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n  = 1'b0;
    start  = 1'b0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    MDU_op = 2'b00;
    Src1   = '0;
    Src2   = '0;
    repeat (3) @(negedge clk);
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (HI !== 32'h0) $display("[TB] FAIL reset_hi: got %h expected 00000000", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'h0) $display("[TB] FAIL reset_lo: got %h expected 00000000", LO); else pass_cnt++;
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_mult();
    int bc; bit gd; bit hd;
    run_op(2'b00, 32'hFFFFFFFD, 32'h00000005, 1'b0, -1, 1'b0, bc, gd, hd);
    total_cnt++; if (gd !== 1'b1) $display("[TB] FAIL mult_done: got %b expected 1", gd); else pass_cnt++;
    total_cnt++; if (bc != 33) $display("[TB] FAIL mult_busy_cycles: got %0d expected 33", bc); else pass_cnt++;
    total_cnt++; if (HI !== 32'hFFFFFFFF) $display("[TB] FAIL mult_hi: got %h expected FFFFFFFF", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'hFFFFFFF1) $display("[TB] FAIL mult_lo: got %h expected FFFFFFF1", LO); else pass_cnt++;
    total_cnt++; if (hd !== 1'b1) $display("[TB] FAIL mult_hold: got %b expected 1", hd); else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (done !== 1'b0 || busy !== 1'b0)
      $display("[TB] FAIL mult_done_pulse: got done=%b busy=%b expected 0 0", done, busy); else pass_cnt++;
  endtask

  task automatic test_multu();
    int bc; bit gd; bit hd;
    run_op(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 10, 1'b1, bc, gd, hd);
    total_cnt++; if (gd !== 1'b1) $display("[TB] FAIL multu_done: got %b expected 1", gd); else pass_cnt++;
    total_cnt++; if (bc != 33) $display("[TB] FAIL multu_busy_cycles: got %0d expected 33", bc); else pass_cnt++;
    total_cnt++; if (hd !== 1'b1) $display("[TB] FAIL multu_hold: got %b expected 1", hd); else pass_cnt++;
    total_cnt++; if (HI !== 32'hFFFFFFFE) $display("[TB] FAIL multu_hi: got %h expected FFFFFFFE", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'h00000001) $display("[TB] FAIL multu_lo: got %h expected 00000001", LO); else pass_cnt++;
  endtask

  task automatic test_div();
    int bc; bit gd; bit hd;
    run_op(2'b10, 32'hFFFFFFF9, 32'h00000002, 1'b0, -1, 1'b0, bc, gd, hd);
    total_cnt++; if (gd !== 1'b1) $display("[TB] FAIL div_neg_done: got %b expected 1", gd); else pass_cnt++;
    total_cnt++; if (LO !== 32'hFFFFFFFD) $display("[TB] FAIL div_neg_lo: got %h expected FFFFFFFD", LO); else pass_cnt++;
    total_cnt++; if (HI !== 32'hFFFFFFFF) $display("[TB] FAIL div_neg_hi: got %h expected FFFFFFFF", HI); else pass_cnt++;
    run_op(2'b10, 32'h80000000, 32'hFFFFFFFF, 1'b0, -1, 1'b0, bc, gd, hd);
    total_cnt++; if (gd !== 1'b1) $display("[TB] FAIL div_ovf_done: got %b expected 1", gd); else pass_cnt++;
    total_cnt++; if (LO !== 32'h80000000) $display("[TB] FAIL div_ovf_lo: got %h expected 80000000", LO); else pass_cnt++;
    total_cnt++; if (HI !== 32'h00000000) $display("[TB] FAIL div_ovf_hi: got %h expected 00000000", HI); else pass_cnt++;
  endtask

  task automatic test_div_by_zero();
    int bc; bit gd; bit hd;
    run_op(2'b11, 32'd100, 32'd0, 1'b0, -1, 1'b0, bc, gd, hd);
    total_cnt++; if (bc != 33) $display("[TB] FAIL divu0_busy_cycles: got %0d expected 33", bc); else pass_cnt++;
    total_cnt++; if (HI !== 32'h00000064) $display("[TB] FAIL divu0_hi: got %h expected 00000064", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'hFFFFFFFF) $display("[TB] FAIL divu0_lo: got %h expected FFFFFFFF", LO); else pass_cnt++;
    run_op(2'b10, 32'hFFFFFFF9, 32'd0, 1'b0, -1, 1'b0, bc, gd, hd);
    total_cnt++; if (HI !== 32'hFFFFFFF9) $display("[TB] FAIL div0_hi: got %h expected FFFFFFF9", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'hFFFFFFFF) $display("[TB] FAIL div0_lo: got %h expected FFFFFFFF", LO); else pass_cnt++;
  endtask

  task automatic test_mthi_mtlo();
    int bc; bit gd; bit hd;
    @(negedge clk);
    mthi = 1'b1;
    Src1 = 32'h12345678;
    @(negedge clk);
    mthi = 1'b0;
    total_cnt++; if (HI !== 32'h12345678) $display("[TB] FAIL mthi_hi: got %h expected 12345678", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'hFFFFFFFF) $display("[TB] FAIL mthi_lo_kept: got %h expected FFFFFFFF", LO); else pass_cnt++;
    mthi = 1'b1;
    mtlo = 1'b1;
    Src1 = 32'hA5A5A5A5;
    @(negedge clk);
    mthi = 1'b0;
    mtlo = 1'b0;
    total_cnt++; if (HI !== 32'hA5A5A5A5 || LO !== 32'hA5A5A5A5)
      $display("[TB] FAIL mthi_mtlo_both: got HI=%h LO=%h expected A5A5A5A5 A5A5A5A5", HI, LO); else pass_cnt++;
    run_op(2'b01, 32'd2, 32'd3, 1'b1, -1, 1'b0, bc, gd, hd);
    total_cnt++; if (hd !== 1'b1) $display("[TB] FAIL mtlo_with_start_hold: got %b expected 1", hd); else pass_cnt++;
    total_cnt++; if (LO !== 32'd6) $display("[TB] FAIL mtlo_with_start_lo: got %h expected 00000006", LO); else pass_cnt++;
    total_cnt++; if (HI !== 32'd0) $display("[TB] FAIL mtlo_with_start_hi: got %h expected 00000000", HI); else pass_cnt++;
    run_op(2'b01, 32'd4, 32'd5, 1'b0, 5, 1'b0, bc, gd, hd);
    total_cnt++; if (hd !== 1'b1) $display("[TB] FAIL mthi_busy_hold: got %b expected 1", hd); else pass_cnt++;
    total_cnt++; if (HI !== 32'd0) $display("[TB] FAIL mthi_busy_hi: got %h expected 00000000", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'd20) $display("[TB] FAIL mthi_busy_lo: got %h expected 00000014", LO); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bc; bit gd; bit hd;
    bit got;
    run_op(2'b11, 32'd9, 32'd3, 1'b0, -1, 1'b0, bc, gd, hd);
    total_cnt++; if (LO !== 32'd3) $display("[TB] FAIL b2b_first_lo: got %h expected 00000003", LO); else pass_cnt++;
    start  = 1'b1;
    MDU_op = 2'b01;
    Src1   = 32'd7;
    Src2   = 32'd6;
    @(negedge clk);
    start = 1'b0;
    total_cnt++; if (busy !== 1'b1) $display("[TB] FAIL b2b_accept: got busy=%b expected 1", busy); else pass_cnt++;
    got = 1'b0;
    for (int n = 0; n < 100; n++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total_cnt++; if (got !== 1'b1) $display("[TB] FAIL b2b_done: got %b expected 1", got); else pass_cnt++;
    total_cnt++; if (LO !== 32'd42 || HI !== 32'd0)
      $display("[TB] FAIL b2b_result: got HI=%h LO=%h expected 00000000 0000002a", HI, LO); else pass_cnt++;
  endtask

  task automatic test_reset_mid_op();
    int bc; bit gd; bit hd;
    bit quiet;
    @(negedge clk);
    mthi = 1'b1;
    Src1 = 32'hCAFEF00D;
    @(negedge clk);
    mthi   = 1'b0;
    start  = 1'b1;
    MDU_op = 2'b11;
    Src1   = 32'd1000;
    Src2   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total_cnt++; if (busy !== 1'b0) $display("[TB] FAIL rstmid_busy: got %b expected 0", busy); else pass_cnt++;
    total_cnt++; if (done !== 1'b0) $display("[TB] FAIL rstmid_done: got %b expected 0", done); else pass_cnt++;
    total_cnt++; if (HI !== 32'h0) $display("[TB] FAIL rstmid_hi: got %h expected 00000000", HI); else pass_cnt++;
    total_cnt++; if (LO !== 32'h0) $display("[TB] FAIL rstmid_lo: got %h expected 00000000", LO); else pass_cnt++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    quiet = 1'b1;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    total_cnt++; if (quiet !== 1'b1) $display("[TB] FAIL rstmid_no_resume: got %b expected 1", quiet); else pass_cnt++;
    run_op(2'b11, 32'd1000, 32'd7, 1'b0, -1, 1'b0, bc, gd, hd);
    total_cnt++; if (bc != 33) $display("[TB] FAIL rstmid_busy_cycles: got %0d expected 33", bc); else pass_cnt++;
    total_cnt++; if (LO !== 32'd142) $display("[TB] FAIL rstmid_lo_after: got %h expected 0000008e", LO); else pass_cnt++;
    total_cnt++; if (HI !== 32'd6) $display("[TB] FAIL rstmid_hi_after: got %h expected 00000006", HI); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_by_zero();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_op();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multi-cycle multiply/divide unit for the MIPS32 datapath. It implements MULT, MULTU, DIV, DIVU, MTHI and MTLO, and holds the architectural HI/LO registers.
- It sits beside the ALU. It takes the same two register-file operands (Src1 = rs, Src2 = rt) and an op code from the control decoder.
- It returns HI/LO to the writeback mux for MFHI/MFLO.
- Busy/done handshake lets the controller stall the pipeline.

Parameters:
- DATA_WIDTH, 32, operand and HI/LO width. Must be a power of two, 8 or greater.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  launch operation; sampled only when busy=0.
- MDU_op  input  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- Src1  input  DATA_WIDTH  multiplicand / dividend (rs).
- Src2  input  DATA_WIDTH  multiplier / divisor (rt).
- mthi  input  1  write Src1 into HI.
- mtlo  input  1  write Src1 into LO.
- busy  output  1  operation in progress.
- done  output  1  one-cycle pulse: HI/LO updated this cycle.
- HI  output  DATA_WIDTH  high product / remainder register.
- LO  output  DATA_WIDTH  low product / quotient register.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low (rst_n).
- Reset while rst_n=0:
  - state=IDLE, busy=0, done=0, HI=0, LO=0, iteration counter=0.
  - All internal operand, partial-product and remainder registers are cleared.
  - A reset mid-operation aborts it; no partial result is ever written.
- FSM states IDLE, CALC, FIX:
  - IDLE: on an edge with start=1, latch the op, the operand magnitudes and the sign bits, clear the accumulator and counter, then go to CALC.
    - Magnitudes are two's-complement absolute values for signed ops and raw values for unsigned ops.
  - CALC: one iteration per edge, exactly DATA_WIDTH edges. Go to FIX after the counter reaches DATA_WIDTH-1.
    - Multiply: shift-add on a 2*DATA_WIDTH accumulator.
    - Divide: restoring, one quotient bit per edge.
  - FIX: apply sign correction and write HI/LO; done=1 for that following cycle; go to IDLE.
- Latency:
  - Start is accepted at edge E0; HI/LO are written at edge E(DATA_WIDTH+1), i.e. E33 at the default width.
  - busy=1 from just after E0 until E33; busy=0 and done=1 in the cycle after E33.
  - The next start can be accepted at E34.
- Sign rules:
  - MULT result is negated if the operand signs differ.
  - DIV quotient sign = sign(Src1) XOR sign(Src2); remainder sign = sign(Src1).
  - Results wrap modulo 2^DATA_WIDTH. Signed 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Division by zero (DIV or DIVU): no trap; full latency still applies; HI=Src1 as sampled at start, LO=all ones.
- Result mapping: multiply gives {HI,LO} = 2*DATA_WIDTH product. Divide gives LO = quotient, HI = remainder.
- HI/LO hold their previous values throughout CALC and are observable unchanged until FIX.
- Handshake:
  - start while busy=1 is ignored; there is no queueing.
  - Src1/Src2 need only be valid at the start edge.
  - mthi/mtlo act only in IDLE and take effect at that edge. Both may be asserted together.
  - start=1 in the same IDLE cycle takes priority: mthi/mtlo are ignored.
  - mthi/mtlo while busy are ignored.
- done never asserts except on FIX exit. No combinational path from inputs to outputs.

Test Plan:
- Reset, then MULT with Src1=0xFFFFFFFD (-3), Src2=5 -> busy high 33 cycles, done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- MULTU with Src1=Src2=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001. A second start pulsed mid-op is ignored and HI/LO keep their old values until done.
- DIV with Src1=0xFFFFFFF9 (-7), Src2=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. Then DIV with 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU with Src1=100, Src2=0 -> after 33 cycles HI=0x00000064, LO=0xFFFFFFFF.
- In IDLE: mthi with Src1=0x12345678 -> HI=0x12345678. Then mtlo together with start (MULTU 2*3) -> mtlo ignored, result LO=6, HI=0. mthi while busy -> ignored.
- Start DIVU 1000/7, drop rst_n at cycle 10 -> busy, done, HI and LO are 0 immediately. After release, the next DIVU 1000/7 -> LO=142, HI=6.
